// File: rtl/pkt_beat_narrower_if.sv
// rtl/pkt_beat_narrower_if.sv - packet stream bundle (data, handshake, delimiters, empty count)
interface pkt_beat_narrower_if #(
    parameter int SYMBOLS         = 16,
    parameter int BITS_PER_SYMBOL = 8
);
    localparam int EW = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;

    logic [SYMBOLS*BITS_PER_SYMBOL-1:0] data;
    logic                               valid;
    logic                               ready;
    logic                               startofpacket;
    logic                               endofpacket;
    logic [EW-1:0]                      empty;

    modport master (
        output data, valid, startofpacket, endofpacket, empty,
        input  ready
    );

    modport slave (
        input  data, valid, startofpacket, endofpacket, empty,
        output ready
    );
endinterface

// File: rtl/pkt_beat_narrower.sv
// rtl/pkt_beat_narrower.sv - splits wide packet beats into narrow beats; optional framing check under PKT_NARROW_ERR_CHECK_EN
module pkt_beat_narrower #(
    parameter int IN_SYMBOLS      = 64,
    parameter int OUT_SYMBOLS     = 16,
    parameter int BITS_PER_SYMBOL = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pkt_beat_narrower_if.slave    in_if,
    pkt_beat_narrower_if.master   out_if,
    output logic                  protocol_err
);
    localparam int R   = IN_SYMBOLS / OUT_SYMBOLS;
    localparam int W   = OUT_SYMBOLS * BITS_PER_SYMBOL;
    localparam int IW  = IN_SYMBOLS * BITS_PER_SYMBOL;
    localparam int KW  = (R > 1) ? $clog2(R) : 1;
    localparam int OEW = (OUT_SYMBOLS > 1) ? $clog2(OUT_SYMBOLS) : 1;
    localparam int OSH = $clog2(OUT_SYMBOLS);
    localparam int VW  = $clog2(IN_SYMBOLS) + 1;

    logic [IW-1:0]  hold_data;
    logic           hold_valid;
    logic           hold_sop;
    logic           hold_eop;
    logic [OEW-1:0] hold_empty;
    logic [KW-1:0]  k;
    logic [KW-1:0]  last_idx;

    logic           at_last;
    logic           fire_in;
    logic           fire_out;
    logic [VW-1:0]  valid_syms;
    logic [VW-1:0]  valid_m1;
    logic [KW-1:0]  cap_last;
    logic [OEW-1:0] cap_empty;
    int             pad_syms;

    assign at_last     = (k == last_idx);
    assign in_if.ready = !hold_valid || (out_if.ready && at_last);
    assign fire_in     = in_if.valid && in_if.ready;
    assign fire_out    = hold_valid && out_if.ready;

    // Derive the final sub-beat index and its empty count for the incoming beat.
    always_comb begin
        valid_syms = VW'(IN_SYMBOLS) - VW'(in_if.empty);
        valid_m1   = valid_syms - VW'(1);
        cap_last   = KW'(R - 1);
        cap_empty  = '0;
        pad_syms   = 0;
        if (in_if.endofpacket) begin
            cap_last  = KW'(valid_m1 >> OSH);
            pad_syms  = (int'(cap_last) + 1) * OUT_SYMBOLS - int'(valid_syms);
            cap_empty = OEW'(pad_syms);
        end
    end

    // Hold register and sub-beat index; a new beat may replace the held one as its last sub-beat leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
            hold_sop   <= 1'b0;
            hold_eop   <= 1'b0;
            hold_empty <= '0;
            k          <= '0;
            last_idx   <= '0;
        end else if (fire_in) begin
            hold_data  <= in_if.data;
            hold_valid <= 1'b1;
            hold_sop   <= in_if.startofpacket;
            hold_eop   <= in_if.endofpacket;
            hold_empty <= cap_empty;
            k          <= '0;
            last_idx   <= cap_last;
        end else if (fire_out) begin
            if (at_last) begin
                hold_valid <= 1'b0;
                k          <= '0;
            end else begin
                k <= k + KW'(1);
            end
        end
    end

    // Narrow beat view of the held word, first symbols taken from the MSB end.
    always_comb begin
        out_if.data          = hold_data[(R - 1 - int'(k)) * W +: W];
        out_if.valid         = hold_valid;
        out_if.startofpacket = hold_valid && hold_sop && (k == '0);
        out_if.endofpacket   = hold_valid && hold_eop && at_last;
        out_if.empty         = (hold_valid && hold_eop && at_last) ? hold_empty : '0;
    end

`ifdef PKT_NARROW_ERR_CHECK_EN
    logic in_pkt;

    // Track packet framing on accepted input beats; any violation latches the error until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_pkt       <= 1'b0;
            protocol_err <= 1'b0;
        end else if (fire_in) begin
            if (in_if.startofpacket == in_pkt) begin
                protocol_err <= 1'b1;
            end
            in_pkt <= !in_if.endofpacket;
        end
    end
`else
    assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_pkt_beat_narrower.sv
// tb/tb_pkt_beat_narrower.sv - directed self-checking bench for pkt_beat_narrower (64 -> 16 symbols)
module tb_pkt_beat_narrower;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic protocol_err;
    int   checks = 0;
    int   errors = 0;

    pkt_beat_narrower_if #(.SYMBOLS(64), .BITS_PER_SYMBOL(8)) in_bus ();
    pkt_beat_narrower_if #(.SYMBOLS(16), .BITS_PER_SYMBOL(8)) out_bus ();

    pkt_beat_narrower #(
        .IN_SYMBOLS(64), .OUT_SYMBOLS(16), .BITS_PER_SYMBOL(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_if(in_bus.slave), .out_if(out_bus.master),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed still running, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [511:0] d, input logic sop, input logic eop, input logic [5:0] emp);
        in_bus.data          = d;
        in_bus.valid         = 1'b1;
        in_bus.startofpacket = sop;
        in_bus.endofpacket   = eop;
        in_bus.empty         = emp;
    endtask

    function automatic logic [511:0] pat(input int seed);
        logic [511:0] v;
        for (int i = 0; i < 64; i++) v[511 - 8*i -: 8] = 8'(seed + 3*i);
        return v;
    endfunction

    function automatic logic [127:0] sub(input logic [511:0] d, input int idx);
        return d[511 - 128*idx -: 128];
    endfunction

    logic [511:0] d1, d2, d3, d5, d6;
    logic [511:0] b [4];

    initial begin
        d1 = pat(0);
        d2 = pat(8'h55);
        d3 = pat(8'hC3);
        d5 = pat(8'h11);
        d6 = pat(8'h77);
        for (int j = 0; j < 4; j++) b[j] = pat(16 * (j + 1) + 1);

        in_bus.data = '0; in_bus.valid = 1'b0; in_bus.startofpacket = 1'b0;
        in_bus.endofpacket = 1'b0; in_bus.empty = '0;
        out_bus.ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", out_bus.valid, 0);
        check("rst_out_data", out_bus.data, 0);
        check("rst_out_empty", out_bus.empty, 0);
        check("rst_err", protocol_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", in_bus.ready, 1);
        check("post_rst_out_valid", out_bus.valid, 0);

        // Single full beat -> four sub-beats
        present(d1, 1, 1, 0);
        tick();
        in_bus.valid = 1'b0;
        for (int kk = 0; kk < 4; kk++) begin
            check("t1_valid", out_bus.valid, 1);
            check("t1_data", out_bus.data, sub(d1, kk));
            check("t1_sop", out_bus.startofpacket, kk == 0);
            check("t1_eop", out_bus.endofpacket, kk == 3);
            check("t1_empty", out_bus.empty, 0);
            check("t1_in_ready", in_bus.ready, kk == 3);
            tick();
        end
        check("t1_drain", out_bus.valid, 0);

        // 24 valid symbols -> two sub-beats, last with empty 8
        present(d2, 1, 1, 40);
        tick();
        in_bus.valid = 1'b0;
        check("t2_b0_data", out_bus.data, sub(d2, 0));
        check("t2_b0_sop", out_bus.startofpacket, 1);
        check("t2_b0_eop", out_bus.endofpacket, 0);
        check("t2_b0_empty", out_bus.empty, 0);
        tick();
        check("t2_b1_valid", out_bus.valid, 1);
        check("t2_b1_data", out_bus.data, sub(d2, 1));
        check("t2_b1_eop", out_bus.endofpacket, 1);
        check("t2_b1_empty", out_bus.empty, 8);
        tick();
        check("t2_drain", out_bus.valid, 0);

        // One valid symbol -> single sub-beat
        present(d3, 1, 1, 63);
        tick();
        in_bus.valid = 1'b0;
        check("t3_valid", out_bus.valid, 1);
        check("t3_data", out_bus.data, d3[511:384]);
        check("t3_sop", out_bus.startofpacket, 1);
        check("t3_eop", out_bus.endofpacket, 1);
        check("t3_empty", out_bus.empty, 15);
        check("t3_in_ready", in_bus.ready, 1);
        tick();
        check("t3_drain", out_bus.valid, 0);

        // Four-beat packet back-to-back at full throughput
        present(b[0], 1, 0, 0);
        tick();
        present(b[1], 0, 0, 0);
        for (int c = 0; c < 16; c++) begin
            check("t4_valid", out_bus.valid, 1);
            check("t4_data", out_bus.data, sub(b[c / 4], c % 4));
            check("t4_in_ready", in_bus.ready, (c % 4) == 3);
            check("t4_sop", out_bus.startofpacket, c == 0);
            check("t4_eop", out_bus.endofpacket, c == 15);
            tick();
            if ((c % 4) == 3) begin
                if (c / 4 + 2 <= 3) present(b[c / 4 + 2], 0, (c / 4 + 2) == 3, 0);
                else in_bus.valid = 1'b0;
            end
        end
        check("t4_drain", out_bus.valid, 0);

        // Backpressure held at sub-beat 1
        present(d5, 1, 1, 0);
        tick();
        present(d6, 1, 1, 0);
        check("t5_k0_data", out_bus.data, sub(d5, 0));
        tick();
        out_bus.ready = 1'b0;
        check("t5_k1_data", out_bus.data, sub(d5, 1));
        for (int s = 0; s < 5; s++) begin
            tick();
            check("t5_stall_valid", out_bus.valid, 1);
            check("t5_stall_data", out_bus.data, sub(d5, 1));
            check("t5_stall_in_ready", in_bus.ready, 0);
            check("t5_stall_eop", out_bus.endofpacket, 0);
        end
        out_bus.ready = 1'b1;
        in_bus.valid = 1'b0;
        tick();
        check("t5_resume_k2", out_bus.data, sub(d5, 2));
        tick();
        check("t5_k3_data", out_bus.data, sub(d5, 3));
        check("t5_k3_eop", out_bus.endofpacket, 1);
        tick();
        check("t5_drain", out_bus.valid, 0);

        // Framing: two sop beats without an eop between them
        present(d1, 1, 0, 0);
        tick();
        in_bus.valid = 1'b0;
        check("t6_err_first", protocol_err, 0);
        for (int s = 0; s < 4; s++) tick();
        check("t6_drained", out_bus.valid, 0);
        present(d2, 1, 0, 0);
        tick();
        in_bus.valid = 1'b0;
`ifdef PKT_NARROW_ERR_CHECK_EN
        check("t6_err_set", protocol_err, 1);
`else
        check("t6_err_tied", protocol_err, 0);
`endif
        check("t6_data_passes", out_bus.data, sub(d2, 0));
        tick();
        tick();
`ifdef PKT_NARROW_ERR_CHECK_EN
        check("t6_err_sticky", protocol_err, 1);
`else
        check("t6_err_still0", protocol_err, 0);
`endif

        // Reset in the middle of a held beat
        check("t7_pre_valid", out_bus.valid, 1);
        rst_n = 1'b0;
        #1;
        check("t7_rst_valid", out_bus.valid, 0);
        check("t7_rst_err", protocol_err, 0);
        check("t7_rst_data", out_bus.data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t7_post_valid", out_bus.valid, 0);
        check("t7_post_in_ready", in_bus.ready, 1);
        tick();
        check("t7_no_partial", out_bus.valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pkt_beat_narrower.md
PKT_BEAT_NARROWER -- requirements
Module: pkt_beat_narrower

Interface
REQ-001 Parameter IN_SYMBOLS, default 64, symbols per input beat; SHALL be a power of two.
REQ-002 Parameter OUT_SYMBOLS, default 16, symbols per output beat; SHALL be a power of two that divides IN_SYMBOLS; R = IN_SYMBOLS/OUT_SYMBOLS.
REQ-003 Parameter BITS_PER_SYMBOL, default 8, bits per symbol.
REQ-004 clk  in  1  single clock; all state SHALL be in this domain.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_data  in  IN_SYMBOLS*BITS_PER_SYMBOL  wide beat; first symbol in MSBs.
REQ-007 in_valid / in_ready  in / out  1 each  input handshake; a beat transfers on in_valid & in_ready.
REQ-008 in_startofpacket, in_endofpacket  in  1 each  packet delimiters.
REQ-009 in_empty  in  log2(IN_SYMBOLS)  unused LSB-end symbols; meaningful only with in_endofpacket.
REQ-010 out_data  out  OUT_SYMBOLS*BITS_PER_SYMBOL  narrow beat; first symbol in MSBs.
REQ-011 out_valid / out_ready  out / in  1 each  output handshake.
REQ-012 out_startofpacket, out_endofpacket  out  1 each  packet delimiters.
REQ-013 out_empty  out  log2(OUT_SYMBOLS)  unused symbols on the final narrow beat.
REQ-014 protocol_err  out  1  sticky framing error flag (see Configuration).

Function
REQ-015 Block SHALL hold one wide beat in a register plus a sub-beat index k (0..R-1) and a last-index L.
REQ-016 in_ready SHALL equal !hold_valid | (out_ready & k==L); a new beat is captured the same cycle the held beat's last sub-beat is accepted.
REQ-017 Latency: beat accepted in cycle T SHALL present sub-beat 0 with out_valid=1 in cycle T+1.
REQ-018 out_data for sub-beat k SHALL be held bits [(R-k)*W-1 : (R-k-1)*W], W = OUT_SYMBOLS*BITS_PER_SYMBOL.
REQ-019 For a non-eop beat, L SHALL be R-1, in_empty ignored, out_empty=0 on every sub-beat.
REQ-020 For an eop beat, V = IN_SYMBOLS - in_empty; L SHALL be ceil(V/OUT_SYMBOLS)-1; sub-beats beyond L SHALL NOT be emitted.
REQ-021 out_empty SHALL be (L+1)*OUT_SYMBOLS - V on sub-beat L of an eop beat, else 0.
REQ-022 out_startofpacket SHALL be 1 only on sub-beat 0 of a sop beat; out_endofpacket only on sub-beat L of an eop beat.
REQ-023 k SHALL advance only on out_valid & out_ready; with out_ready low all outputs SHALL hold stable.
REQ-024 If k==L is accepted and no input is available, out_valid SHALL drop to 0 next cycle.
REQ-025 Full throughput: with in_valid and out_ready continuously high, out_valid SHALL stay high with no bubble between wide beats.

Reset
REQ-026 On rst_n low, hold_valid, k, out_valid, out_startofpacket, out_endofpacket, out_empty, protocol_err SHALL clear to 0 immediately; out_data SHALL reset to 0.
REQ-027 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-028 Reset mid-packet SHALL discard the held beat; no partial output after release.

Configuration
REQ-029 Macro PKT_NARROW_ERR_CHECK_EN SHALL compile in framing checking.
REQ-030 With it: in_pkt state tracked on accepted input beats; sop while in_pkt, or non-sop beat while !in_pkt, SHALL set protocol_err (sticky until reset); data still passes unchanged.
REQ-031 Without it: protocol_err SHALL be tied 0 and no tracking logic built.

Verification (IN=64, OUT=16, BPS=8, R=4)
REQ-032 One beat sop=eop=1, empty=0, out_ready=1 -> 4 consecutive out beats, sop on first, eop on fourth, out_empty=0.
REQ-033 Beat sop=eop=1, empty=40 (24 valid) -> 2 out beats; second has eop=1, out_empty=8.
REQ-034 Beat sop=eop=1, empty=63 -> 1 out beat with sop=eop=1, out_empty=15, data = input bits [511:384].
REQ-035 4-beat packet back-to-back, out_ready=1 -> 16 consecutive out_valid cycles; in_ready high only on cycles where k=3.
REQ-036 out_ready low 5 cycles at k=1 -> out_data/out_valid/k stable, in_ready=0; resumes with k=2.
REQ-037 Macro defined: two sop beats without eop -> protocol_err=1 next cycle and stays 1; macro undefined -> protocol_err stays 0.
